// File: rtl/sort_ctrl_pkg.sv
// Shared types and constants for the sort-engine step scheduler.
// Holds the controller state encoding, default rate table and period helpers.
package sort_ctrl_pkg;

   localparam int PERIOD_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [PERIOD_W-1:0] RATE0_DEF = 32'd50_000_000;
   localparam logic [PERIOD_W-1:0] RATE1_DEF = 32'd25_000_000;
   localparam logic [PERIOD_W-1:0] RATE2_DEF = 32'd5_000_000;
   localparam logic [PERIOD_W-1:0] RATE3_DEF = 32'd1;

   // A zero period would never wrap; treat it as the fastest rate instead.
   function automatic logic [PERIOD_W-1:0] map_period(input logic [PERIOD_W-1:0] m);
      return (m == '0) ? PERIOD_W'(1) : m;
   endfunction

endpackage

// File: rtl/step_period_counter.sv
// Programmable period counter: counts 0..cur_m-1 while enabled and flags the wrap.
// A newly loaded period waits in pending_m until a wrap, unless the counter is idle.
module step_period_counter
   import sort_ctrl_pkg::*;
#(
   parameter logic [PERIOD_W-1:0] INIT_M = RATE0_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr_i,
   input  logic                en_i,
   input  logic                run_mode_i,
   input  logic                rate_load_i,
   input  logic [PERIOD_W-1:0] load_m_i,
   output logic                tick_o,
   output logic [PERIOD_W-1:0] cur_m_o
);

   logic [PERIOD_W-1:0] count_q, count_d;
   logic [PERIOD_W-1:0] cur_m_q, cur_m_d;
   logic [PERIOD_W-1:0] pending_m_q, pending_m_d;
   logic                wrap;

   assign wrap    = en_i && (count_q == (cur_m_q - PERIOD_W'(1)));
   assign tick_o  = wrap;
   assign cur_m_o = cur_m_q;

   always_comb begin
      count_d     = count_q;
      cur_m_d     = cur_m_q;
      pending_m_d = pending_m_q;
      if (en_i) begin
         if (wrap) begin
            count_d = '0;
            cur_m_d = pending_m_q;
         end else begin
            count_d = count_q + PERIOD_W'(1);
         end
      end
      // Outside RUN there is no period in flight, so the new rate applies at once.
      if (rate_load_i) begin
         pending_m_d = load_m_i;
         if (!run_mode_i) begin
            cur_m_d = load_m_i;
            count_d = '0;
         end
      end
      if (clr_i) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q     <= '0;
         cur_m_q     <= INIT_M;
         pending_m_q <= INIT_M;
      end else begin
         count_q     <= count_d;
         cur_m_q     <= cur_m_d;
         pending_m_q <= pending_m_d;
      end
   end

endmodule

// File: rtl/sort_step_scheduler.sv
// Paces the insertion-sort engine: run/pause/single-step FSM issuing step requests
// over valid/ready, with a saturating count of ticks dropped while a step is pending.
module sort_step_scheduler
   import sort_ctrl_pkg::*;
#(
   parameter logic [PERIOD_W-1:0] RATE0 = RATE0_DEF,
   parameter logic [PERIOD_W-1:0] RATE1 = RATE1_DEF,
   parameter logic [PERIOD_W-1:0] RATE2 = RATE2_DEF,
   parameter logic [PERIOD_W-1:0] RATE3 = RATE3_DEF,
   parameter int                  OVR_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          rate_sel,
   input  logic                rate_load,
   input  logic                run,
   input  logic                step_btn,
   input  logic                clr,
   input  logic                done,
   output logic                step_valid,
   input  logic                step_ready,
   output logic [PERIOD_W-1:0] cur_m,
   output logic [1:0]          state,
   output logic [OVR_W-1:0]    overrun
);

   localparam logic [PERIOD_W-1:0] INIT_M = map_period(RATE0);

   state_e              state_q, state_d;
   logic                valid_q, valid_d;
   logic [OVR_W-1:0]    ovr_q, ovr_d;
   logic [PERIOD_W-1:0] rate_raw;
   logic                cnt_en;
   logic                wrap_tick;
   logic                step_tick;

   always_comb begin
      rate_raw = RATE0;
      unique case (rate_sel)
         2'd0: rate_raw = RATE0;
         2'd1: rate_raw = RATE1;
         2'd2: rate_raw = RATE2;
         2'd3: rate_raw = RATE3;
      endcase
   end

   assign cnt_en = (state_q == ST_RUN) && !clr;

   step_period_counter #(
      .INIT_M(INIT_M)
   ) u_period (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (clr),
      .en_i       (cnt_en),
      .run_mode_i (state_q == ST_RUN),
      .rate_load_i(rate_load),
      .load_m_i   (map_period(rate_raw)),
      .tick_o     (wrap_tick),
      .cur_m_o    (cur_m)
   );

   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      ovr_d     = ovr_q;
      step_tick = 1'b0;
      if (clr) begin
         state_d = ST_IDLE;
         valid_d = 1'b0;
         ovr_d   = '0;
      end else if (done && (state_q != ST_DONE)) begin
         // The engine ignores requests once sorted, so withdraw any outstanding one.
         state_d = ST_DONE;
         valid_d = 1'b0;
      end else if (state_q != ST_DONE) begin
         unique case (state_q)
            ST_IDLE: begin
               if (run) begin
                  state_d = ST_RUN;
               end else if (step_btn) begin
                  state_d   = ST_PAUSE;
                  step_tick = 1'b1;
               end
            end
            ST_RUN: begin
               step_tick = wrap_tick;
               if (!run) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
               step_tick = step_btn;
               if (run) state_d = ST_RUN;
            end
            ST_DONE: state_d = ST_DONE;
         endcase
         if (step_tick) begin
            if (valid_q && !step_ready && (ovr_q != '1)) begin
               ovr_d = ovr_q + OVR_W'(1);
            end
            valid_d = 1'b1;
         end else if (valid_q && step_ready) begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         valid_q <= 1'b0;
         ovr_q   <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign state      = state_q;
   assign step_valid = valid_q;
   assign overrun    = ovr_q;

endmodule
